// File: rtl/led_chaser_pkg.sv
// rtl/led_chaser_pkg.sv - shared mode codes and direction constants for the LED chaser
//   Provides: mode_t (MODE_IDLE/LEFT/RIGHT/PP), DIR_LEFT/DIR_RIGHT.
package led_chaser_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_LEFT  = 2'd1,
        MODE_RIGHT = 2'd2,
        MODE_PP    = 2'd3
    } mode_t;

    // Ping-pong travel direction: left moves the lit lamp toward the MSB.
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/led_chaser_nch_step_timer.sv
// rtl/led_chaser_nch_step_timer.sv - step period counter producing a terminal-count tick
//   Ports: clk, rst (sync, active-high), en (count enable), clr (clear, wins over en),
//          tick (combinational: high on the edge where the counter wraps to 0).
module led_step_timer #(
    parameter int unsigned STEP_CYC = 50_000_000,
    parameter int          CNT_W    = $clog2(STEP_CYC)
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(STEP_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    // A clear on the terminal-count edge suppresses the tick, so a command
    // or stop accepted on that edge never produces a shift.
    assign tick = en & ~clr & (r_cnt == TERM);

    always_ff @(posedge clk) begin
        if (rst || clr || !en || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_chaser_nch.sv
// rtl/led_chaser_nch.sv - one-hot LED chaser with left/right/ping-pong modes and stop
//   Ports: clk, rst (sync, active-high), flag_left/flag_right/flag_pp/flag_stop (rising-edge
//          commands, priority stop > left > right > pp), pio_led[LED_W] (one-hot lamps),
//          mode[2] (mode_t code), step (pulse coincident with each pattern shift).
//   Macro LED_CHASER_PINGPONG_EN: builds ping-pong mode and its direction register;
//          when undefined flag_pp is ignored.
module led_chaser_nch
    import led_chaser_pkg::*;
#(
    parameter int          LED_W    = 4,
    parameter int unsigned STEP_CYC = 50_000_000,
    parameter int          CNT_W    = $clog2(STEP_CYC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flag_left,
    input  logic             flag_right,
    input  logic             flag_pp,
    input  logic             flag_stop,
    output logic [LED_W-1:0] pio_led,
    output logic [1:0]       mode,
    output logic             step
);

    logic r_left_d;
    logic r_right_d;
    logic r_stop_d;
    logic w_left_rise;
    logic w_right_rise;
    logic w_stop_rise;
    logic w_pp_rise;

    mode_t            r_mode;
    mode_t            w_mode_nxt;
    logic             w_cmd;
    logic             w_tick;
    logic [LED_W-1:0] r_led;
    logic             r_step;
    logic [LED_W-1:0] w_led_l;
    logic [LED_W-1:0] w_led_r;

    assign w_left_rise  = flag_left  & ~r_left_d;
    assign w_right_rise = flag_right & ~r_right_d;
    assign w_stop_rise  = flag_stop  & ~r_stop_d;

`ifdef LED_CHASER_PINGPONG_EN
    logic r_pp_d;
    logic r_dir;
    assign w_pp_rise = flag_pp & ~r_pp_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pp_d <= 1'b0;
        end else begin
            r_pp_d <= flag_pp;
        end
    end
`else
    logic w_unused_pp;
    assign w_unused_pp = flag_pp;
    assign w_pp_rise   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_left_d  <= 1'b0;
            r_right_d <= 1'b0;
            r_stop_d  <= 1'b0;
        end else begin
            r_left_d  <= flag_left;
            r_right_d <= flag_right;
            r_stop_d  <= flag_stop;
        end
    end

    // Command arbitration: only the highest-priority rising flag is accepted.
    always_comb begin
        w_mode_nxt = r_mode;
        w_cmd      = 1'b0;
        if (w_stop_rise) begin
            w_mode_nxt = MODE_IDLE;
            w_cmd      = 1'b1;
        end else if (w_left_rise) begin
            w_mode_nxt = MODE_LEFT;
            w_cmd      = 1'b1;
        end else if (w_right_rise) begin
            w_mode_nxt = MODE_RIGHT;
            w_cmd      = 1'b1;
        end else if (w_pp_rise) begin
            w_mode_nxt = MODE_PP;
            w_cmd      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= MODE_IDLE;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    led_step_timer #(
        .STEP_CYC (STEP_CYC),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (r_mode != MODE_IDLE),
        .clr  (w_cmd),
        .tick (w_tick)
    );

    assign w_led_l = {r_led[LED_W-2:0], r_led[LED_W-1]};
    assign w_led_r = {r_led[0], r_led[LED_W-1:1]};

    // The pattern only ever rotates, so the single lit bit is preserved.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led  <= LED_W'(1);
            r_step <= 1'b0;
        end else begin
            r_step <= w_tick;
            if (w_tick) begin
                case (r_mode)
                    MODE_LEFT:  r_led <= w_led_l;
                    MODE_RIGHT: r_led <= w_led_r;
`ifdef LED_CHASER_PINGPONG_EN
                    MODE_PP:    r_led <= (r_dir == DIR_LEFT) ? w_led_l : w_led_r;
`endif
                    default:    r_led <= r_led;
                endcase
            end
        end
    end

`ifdef LED_CHASER_PINGPONG_EN
    // Direction flips on the step that lands on an end lamp, so the end lamp
    // stays lit for one period and the rotation never wraps in PP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir <= DIR_LEFT;
        end else if (w_cmd && (w_mode_nxt == MODE_PP)) begin
            r_dir <= r_led[LED_W-1] ? DIR_RIGHT : DIR_LEFT;
        end else if (w_tick && (r_mode == MODE_PP)) begin
            if ((r_dir == DIR_LEFT) && w_led_l[LED_W-1]) begin
                r_dir <= DIR_RIGHT;
            end else if ((r_dir == DIR_RIGHT) && w_led_r[0]) begin
                r_dir <= DIR_LEFT;
            end
        end
    end
`endif

    assign pio_led = r_led;
    assign mode    = r_mode;
    assign step    = r_step;

endmodule
